// File: rtl/butterfly_sm_pipe_if.sv
// rtl/butterfly_sm_pipe_if.sv - operand/result handshake bundle for the butterfly stage
interface butterfly_sm_pipe_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_a;
    logic [2*N-1:0]   in_bw;
    logic             in_mul_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_x0;
    logic [2*N-1:0]   out_x1;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_bw, in_mul_ovf, out_ready,
        output in_ready, out_valid, out_x0, out_x1, out_ovf
    );

    modport master (
        output in_valid, in_a, in_bw, in_mul_ovf, out_ready,
        input  in_ready, out_valid, out_x0, out_x1, out_ovf
    );
endinterface

// File: rtl/butterfly_sm_pipe.sv
// rtl/butterfly_sm_pipe.sv - 2-stage sign-magnitude radix-2 butterfly (X0=A+BW, X1=A-BW)
module butterfly_sm_pipe #(
    parameter int N     = 8,
    parameter int Q     = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    butterfly_sm_pipe_if.slave bus,
    input  logic             ovf_clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] pair_cnt
);
    localparam int M = N - 1;
    localparam logic [M-1:0] MAG_MAX = '1;

    if (Q > N - 1) begin : g_bad_q
        $error("Q exceeds the magnitude width");
    end

    // Returns {overflow, sign, magnitude}; -0 operands are folded to +0 first.
    function automatic logic [N:0] sm_add(input logic sa, input logic [M-1:0] ma,
                                          input logic sb, input logic [M-1:0] mb,
                                          input logic a_gt, input logic a_eq);
        logic         sa_e;
        logic         sb_e;
        logic [M:0]   sum;
        logic [N:0]   r;
        sa_e = sa & (|ma);
        sb_e = sb & (|mb);
        sum  = {1'b0, ma} + {1'b0, mb};
        r    = '0;
        if (sa_e == sb_e) begin
            if (sum[M]) r = {1'b1, sa_e, MAG_MAX};
            else        r = {1'b0, sa_e, sum[M-1:0]};
        end else if (a_eq) begin
            r = '0;
        end else if (a_gt) begin
            r = {1'b0, sa_e, ma - mb};
        end else begin
            r = {1'b0, sb_e, mb - ma};
        end
        return r;
    endfunction

    logic             s1_valid_q;
    logic [2*N-1:0]   a_q;
    logic [2*N-1:0]   bw_q;
    logic             mulovf_q;
    logic [1:0]       gt_q;
    logic [1:0]       eq_q;
    logic             s2_valid_q;
    logic [2*N-1:0]   x0_q;
    logic [2*N-1:0]   x1_q;
    logic             ovf_q;
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             deliver;
    logic [1:0]       gt_d;
    logic [1:0]       eq_d;
    logic [N:0]       re0;
    logic [N:0]       re1;
    logic [N:0]       im0;
    logic [N:0]       im1;
    logic [2*N-1:0]   x0_d;
    logic [2*N-1:0]   x1_d;
    logic             ovf_d;

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;
    assign deliver      = s2_valid_q && bus.out_ready;

    assign gt_d = {bus.in_a[2*N-2:N] > bus.in_bw[2*N-2:N], bus.in_a[N-2:0] > bus.in_bw[N-2:0]};
    assign eq_d = {bus.in_a[2*N-2:N] == bus.in_bw[2*N-2:N], bus.in_a[N-2:0] == bus.in_bw[N-2:0]};

    // X1 reuses the adder with BW's sign flipped; the registered compare is sign-independent.
    assign re0 = sm_add(a_q[2*N-1], a_q[2*N-2:N], bw_q[2*N-1], bw_q[2*N-2:N], gt_q[1], eq_q[1]);
    assign re1 = sm_add(a_q[2*N-1], a_q[2*N-2:N], ~bw_q[2*N-1], bw_q[2*N-2:N], gt_q[1], eq_q[1]);
    assign im0 = sm_add(a_q[N-1], a_q[N-2:0], bw_q[N-1], bw_q[N-2:0], gt_q[0], eq_q[0]);
    assign im1 = sm_add(a_q[N-1], a_q[N-2:0], ~bw_q[N-1], bw_q[N-2:0], gt_q[0], eq_q[0]);

    assign x0_d  = {re0[N-1:0], im0[N-1:0]};
    assign x1_d  = {re1[N-1:0], im1[N-1:0]};
    assign ovf_d = mulovf_q | re0[N] | re1[N] | im0[N] | im1[N];

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (deliver && ovf_q) sticky_d = 1'b1;
        else if (ovf_clr)     sticky_d = 1'b0;
        if (deliver)          cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            bw_q       <= '0;
            mulovf_q   <= 1'b0;
            gt_q       <= '0;
            eq_q       <= '0;
            s2_valid_q <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            ovf_q      <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    a_q      <= bus.in_a;
                    bw_q     <= bus.in_bw;
                    mulovf_q <= bus.in_mul_ovf;
                    gt_q     <= gt_d;
                    eq_q     <= eq_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    x0_q  <= x0_d;
                    x1_q  <= x1_d;
                    ovf_q <= ovf_d;
                end
            end
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_x0    = x0_q;
    assign bus.out_x1    = x1_q;
    assign bus.out_ovf   = ovf_q;
    assign ovf_sticky    = sticky_q;
    assign pair_cnt      = cnt_q;
endmodule

// File: tb/tb_butterfly_sm_pipe.sv
// tb/tb_butterfly_sm_pipe.sv - scoreboard bench for butterfly_sm_pipe
module tb_butterfly_sm_pipe;
    localparam int N = 8;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] x1;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ovf_clr;
    logic ovf_sticky;
    logic [CNT_W-1:0] pair_cnt;

    butterfly_sm_pipe_if #(.N(N)) bus ();

    butterfly_sm_pipe #(.N(N), .Q(6), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .pair_cnt   (pair_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cnt_model = 0;

    // Reference: convert to signed integers, add, clamp to +-127, convert back (zero is always +0).
    function automatic logic [7:0] ref_half(input logic [7:0] a, input logic [7:0] b,
                                            input bit neg_b, output bit ovf);
        int va, vb, s;
        logic [6:0] m;
        va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
        if (neg_b) vb = -vb;
        s = va + vb;
        ovf = 1'b0;
        if (s > 127) begin s = 127; ovf = 1'b1; end
        else if (s < -127) begin s = -127; ovf = 1'b1; end
        if (s < 0) begin m = 7'(-s); return {1'b1, m}; end
        m = 7'(s);
        return {1'b0, m};
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] bw, input bit mo);
        exp_t e;
        bit o0, o1, o2, o3;
        e.x0  = {ref_half(a[15:8], bw[15:8], 1'b0, o0), ref_half(a[7:0], bw[7:0], 1'b0, o1)};
        e.x1  = {ref_half(a[15:8], bw[15:8], 1'b1, o2), ref_half(a[7:0], bw[7:0], 1'b1, o3)};
        e.ovf = mo | o0 | o1 | o2 | o3;
        return e;
    endfunction

    // Called at posedge+1; returns just after the accept edge.
    task automatic send_one(input logic [15:0] a, input logic [15:0] bw, input bit mo, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_bw = bw; bus.in_mul_ovf = mo;
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready) begin ok = 1'b1; sb_q.push_back(model(a, bw, mo)); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.in_mul_ovf = 1'b0;
    endtask

    // Assumes out_ready=1; captures the pair and steps past its delivery edge.
    task automatic recv_one(output bit ok, output exp_t got);
        ok = 1'b0; got = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1; got = {bus.out_x0, bus.out_x1, bus.out_ovf}; cnt_model++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if ({bus.out_x0, bus.out_x1, bus.out_ovf} !== 33'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {bus.out_x0, bus.out_x1, bus.out_ovf}); end
        tests_run++; if ({ovf_sticky, pair_cnt} !== 9'd0) begin tests_failed++; $display("FAIL reset_sticky_cnt: got %h expected 0", {ovf_sticky, pair_cnt}); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bit ok; exp_t got, e;
        send_one(16'h2000, 16'h1000, 1'b0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_accept: got timeout expected accept"); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_lat1: got %b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_lat2: got %b expected 1", bus.out_valid); end
        recv_one(ok, got);
        e = sb_q.pop_front();
        tests_run++; if (got !== {16'h3000, 16'h1000, 1'b0}) begin tests_failed++; $display("FAIL basic_value: got %h expected %h", got, {16'h3000, 16'h1000, 1'b0}); end
        tests_run++; if (got !== e) begin tests_failed++; $display("FAIL basic_model: got %h expected %h", got, e); end
        tests_run++; if (pair_cnt !== CNT_W'(cnt_model)) begin tests_failed++; $display("FAIL basic_cnt: got %0d expected %0d", pair_cnt, cnt_model); end
    endtask

    task automatic test_mixed_sign();
        logic [15:0] ta[4], tbw[4], tx0[4], tx1[4];
        bit ok; exp_t got, e;
        ta[0] = 16'hA000; tbw[0] = 16'h1000; tx0[0] = 16'h9000; tx1[0] = 16'hB000;
        ta[1] = 16'h2085; tbw[1] = 16'h2005; tx0[1] = 16'h4000; tx1[1] = 16'h008A;
        ta[2] = 16'h8080; tbw[2] = 16'h8000; tx0[2] = 16'h0000; tx1[2] = 16'h0000;
        ta[3] = 16'h8000; tbw[3] = 16'h0510; tx0[3] = 16'h0510; tx1[3] = 16'h8590;
        for (int i = 0; i < 4; i++) begin
            send_one(ta[i], tbw[i], 1'b0, ok);
            recv_one(ok, got);
            e = sb_q.pop_front();
            tests_run++; if (!ok || got.x0 !== tx0[i] || got.x1 !== tx1[i] || got.ovf !== 1'b0) begin tests_failed++; $display("FAIL mixed_sign_%0d: got %h expected %h", i, got, {tx0[i], tx1[i], 1'b0}); end
            tests_run++; if (got !== e) begin tests_failed++; $display("FAIL mixed_model_%0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_saturation();
        bit ok; exp_t got, e;
        send_one(16'h6000, 16'h4000, 1'b0, ok);
        recv_one(ok, got);
        e = sb_q.pop_front();
        tests_run++; if (got !== {16'h7F00, 16'h2000, 1'b1} || got !== e) begin tests_failed++; $display("FAIL sat_value: got %h expected %h", got, {16'h7F00, 16'h2000, 1'b1}); end
        tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL sat_sticky_set: got %b expected 1", ovf_sticky); end
        ovf_clr = 1'b1;
        send_one(16'h1000, 16'h1000, 1'b0, ok);
        recv_one(ok, got);
        ovf_clr = 1'b0;
        e = sb_q.pop_front();
        tests_run++; if (got !== e || got.ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_clean: got %h expected %h", got, e); end
        tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL sat_sticky_clr: got %b expected 0", ovf_sticky); end
        // Clear coinciding with an overflowing delivery: set must win.
        bus.out_ready = 1'b0;
        send_one(16'hE0E0, 16'hC0C0, 1'b0, ok);
        @(posedge clk); #1;
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_stall_valid: got %b expected 1", bus.out_valid); end
        got = {bus.out_x0, bus.out_x1, bus.out_ovf};
        ovf_clr = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0; cnt_model++;
        e = sb_q.pop_front();
        tests_run++; if (got !== e) begin tests_failed++; $display("FAIL sat_neg_value: got %h expected %h", got, e); end
        tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL sat_set_wins: got %b expected 1", ovf_sticky); end
    endtask

    task automatic test_mul_ovf();
        bit ok; exp_t got, e;
        bit mo[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_one(16'h1000, 16'h0800, mo[i], ok);
            recv_one(ok, got);
            e = sb_q.pop_front();
            tests_run++; if (got.ovf !== mo[i] || got !== e) begin tests_failed++; $display("FAIL mul_ovf_%0d: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] da[8], db[8];
        bit dm[8];
        int acc_n = 0, dlv_n = 0, cyc = 0;
        bit stalled = 1'b0;
        exp_t held = '0, got, e;
        for (int i = 0; i < 8; i++) begin
            da[i] = 16'($urandom); db[i] = 16'($urandom); dm[i] = ($urandom_range(0, 7) == 0);
        end
        while (dlv_n < 8 && cyc < 300) begin
            bus.out_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
            if (acc_n < 8) begin
                bus.in_valid = 1'b1; bus.in_a = da[acc_n]; bus.in_bw = db[acc_n]; bus.in_mul_ovf = dm[acc_n];
            end else bus.in_valid = 1'b0;
            #1;
            got = {bus.out_x0, bus.out_x1, bus.out_ovf};
            if (stalled) begin
                tests_run++; if (bus.out_valid !== 1'b1 || got !== held) begin tests_failed++; $display("FAIL bp_stable: got %b/%h expected 1/%h", bus.out_valid, got, held); end
            end
            tests_run++; if (bus.in_ready !== ((acc_n - dlv_n) < 2 || bus.out_ready)) begin tests_failed++; $display("FAIL bp_in_ready: got %b expected %b", bus.in_ready, ((acc_n - dlv_n) < 2 || bus.out_ready)); end
            if (bus.out_valid && bus.out_ready) begin
                e = sb_q.pop_front();
                tests_run++; if (got !== e) begin tests_failed++; $display("FAIL bp_data_%0d: got %h expected %h", dlv_n, got, e); end
                dlv_n++; cnt_model++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = got;
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bus.in_a, bus.in_bw, bus.in_mul_ovf)); acc_n++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0; bus.in_mul_ovf = 1'b0; bus.out_ready = 1'b1;
        tests_run++; if (dlv_n != 8) begin tests_failed++; $display("FAIL bp_count: got %0d expected 8", dlv_n); end
        tests_run++; if (pair_cnt !== CNT_W'(cnt_model)) begin tests_failed++; $display("FAIL bp_cnt: got %0d expected %0d", pair_cnt, cnt_model); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        bus.out_ready = 1'b0;
        send_one(16'h1111, 16'h0202, 1'b1, ok);
        send_one(16'h2222, 16'h0303, 1'b0, ok);
        #2; rst_n = 1'b0; #1;
        sb_q.delete(); cnt_model = 0;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.out_x0 !== 16'h0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b/%h expected 0/0000", bus.out_valid, bus.out_x0); end
        tests_run++; if (pair_cnt !== 8'd0 || ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_state: got %0d/%b expected 0/0", pair_cnt, ovf_sticky); end
        @(posedge clk); #1; rst_n = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ghost_%0d: got %b expected 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_wrap();
        int acc_n = 0, dlv_n = 0, cyc = 0;
        exp_t got, e;
        bus.out_ready = 1'b1;
        while (dlv_n < 256 && cyc < 400) begin
            tests_run++; if (pair_cnt !== CNT_W'(dlv_n)) begin tests_failed++; $display("FAIL wrap_cnt_%0d: got %0d expected %0d", dlv_n, pair_cnt, dlv_n % 256); end
            bus.in_valid = (acc_n < 256);
            bus.in_a = 16'($urandom); bus.in_bw = 16'($urandom); bus.in_mul_ovf = 1'b0;
            #1;
            tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL wrap_in_ready: got %b expected 1", bus.in_ready); end
            if (bus.out_valid) begin
                got = {bus.out_x0, bus.out_x1, bus.out_ovf};
                e = sb_q.pop_front();
                tests_run++; if (got !== e) begin tests_failed++; $display("FAIL wrap_data_%0d: got %h expected %h", dlv_n, got, e); end
                dlv_n++;
            end
            if (bus.in_valid) begin sb_q.push_back(model(bus.in_a, bus.in_bw, 1'b0)); acc_n++; end
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        tests_run++; if (dlv_n != 256) begin tests_failed++; $display("FAIL wrap_count: got %0d expected 256", dlv_n); end
        tests_run++; if (pair_cnt !== 8'd0) begin tests_failed++; $display("FAIL wrap_final: got %0d expected 0", pair_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ovf_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_bw = '0; bus.in_mul_ovf = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_mixed_sign();
        test_saturation();
        test_mul_ovf();
        test_backpressure();
        test_reset_midstream();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
